// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D main-memory port arbiter: FSM state encoding and grant ids.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_FILL = 3'd1,
        D_WB   = 3'd2,
        D_FILL = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side request/fill signals plus the main-memory port, bundled for the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_cancel;
    logic              i_fill_valid;
    logic [LINE_W-1:0] i_fill_data;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wb_needed;
    logic [ADDR_W-1:0] d_wb_addr;
    logic [LINE_W-1:0] d_wb_data;
    logic              d_fill_valid;
    logic [LINE_W-1:0] d_fill_data;
    logic              d_pending;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    // master: caches and memory device; slave: the arbiter
    modport master (
        output i_req, i_addr, i_cancel,
        output d_req, d_addr, d_wb_needed, d_wb_addr, d_wb_data,
        output mem_rdata,
        input  i_fill_valid, i_fill_data, d_fill_valid, d_fill_data, d_pending,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, i_cancel,
        input  d_req, d_addr, d_wb_needed, d_wb_addr, d_wb_data,
        input  mem_rdata,
        output i_fill_valid, i_fill_data, d_fill_valid, d_fill_data, d_pending,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_counter.sv
// Per-access down-counter: loads MEM_LATENCY-1 on access-state entry, done when it reaches 0.
module mem_latency_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    // A one-cycle latency still needs a 1-bit register that simply stays at 0.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] INIT = CW'(MEM_LATENCY - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)            cnt <= '0;
        else if (load)        cnt <= INIT;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between I-cache fills and D-cache write-back+fill,
// holding each access stable for MEM_LATENCY cycles and pulsing one response per transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 5
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    state_t            state, nxt;
    logic              last_grant, cancelled;
    logic              iq, dq, gnt_i, gnt_d, load, done;
    logic [ADDR_W-1:0] fill_addr, addr_q;
    logic [LINE_W-1:0] wdata_q, i_data_q, d_data_q;

    // A cancelled I request never competes for the port.
    assign iq    = bus.i_req && !bus.i_cancel;
    assign dq    = bus.d_req;
    assign gnt_d = dq && (!iq || last_grant == GNT_I);
    assign gnt_i = iq && !gnt_d;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (gnt_d)      nxt = bus.d_wb_needed ? D_WB : D_FILL;
                else if (gnt_i) nxt = I_FILL;
            end
            I_FILL, D_FILL: if (done) nxt = RESP;
            D_WB:           if (done) nxt = D_FILL;
            RESP:           nxt = IDLE;
            default:        nxt = IDLE;
        endcase
    end

    // D_WB -> D_FILL counts as an entry too, so the read gets its own full latency.
    assign load = (nxt != state) && (nxt == I_FILL || nxt == D_WB || nxt == D_FILL);

    mem_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            cancelled  <= 1'b0;
            fill_addr  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_data_q   <= '0;
            d_data_q   <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (gnt_d) begin
                        last_grant <= GNT_D;
                        fill_addr  <= bus.d_addr;
                        wdata_q    <= bus.d_wb_data;
                        addr_q     <= bus.d_wb_needed ? bus.d_wb_addr : bus.d_addr;
                    end else if (gnt_i) begin
                        last_grant <= GNT_I;
                        addr_q     <= bus.i_addr;
                    end
                end
                I_FILL: begin
                    if (bus.i_cancel) cancelled <= 1'b1;
                    if (done)         i_data_q  <= bus.mem_rdata;
                end
                D_WB:   if (done) addr_q   <= fill_addr;
                D_FILL: if (done) d_data_q <= bus.mem_rdata;
                RESP:   cancelled <= 1'b0;
                default: ;
            endcase
        end
    end

    // last_grant still names the owner while in RESP, so it doubles as the response selector.
    assign bus.mem_req      = (state == I_FILL) || (state == D_WB) || (state == D_FILL);
    assign bus.mem_we       = (state == D_WB);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.i_fill_valid = (state == RESP) && (last_grant == GNT_I) && !cancelled;
    assign bus.d_fill_valid = (state == RESP) && (last_grant == GNT_D);
    assign bus.i_fill_data  = i_data_q;
    assign bus.d_fill_data  = d_data_q;
    assign bus.d_pending    = (state == D_WB) || (state == D_FILL) ||
                              ((state == RESP) && (last_grant == GNT_D));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: caches + memory device around mem_port_arbiter, directed scenarios then random traffic.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int L  = 5;
    localparam int NLOG = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus();

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [LW-1:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {4{8'hA5, b, 16'h5A5A}};
    endfunction

    // Memory device: line-indexed array, read data always presented for the current address.
    logic [LW-1:0] dev_mem [64];
    assign bus.mem_rdata = dev_mem[bus.mem_addr[9:4]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= init_val(i);
        end else if (bus.mem_req && bus.mem_we) begin
            dev_mem[bus.mem_addr[9:4]] <= bus.mem_wdata;
        end
    end

    // Reference: what each line must hold, updated at request time.
    logic [LW-1:0] ref_mem [64];

    typedef struct { logic [LW-1:0] data; int cyc; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } wb_t;
    exp_t i_exp[$];
    exp_t d_exp[$];
    wb_t  wb_exp[$];
    int   grant_log[$];

    int total = 0;
    int bad = 0;
    int i_resp_cnt = 0, d_resp_cnt = 0, i_seen = 0, d_seen = 0;
    bit i_busy = 0, d_busy = 0;

    bit            lg_req [NLOG];
    bit            lg_we  [NLOG];
    bit            lg_iv  [NLOG];
    bit            lg_dv  [NLOG];
    bit            lg_dp  [NLOG];
    logic [AW-1:0] lg_addr[NLOG];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, req);
        end
    endtask

    // Monitor: logs every cycle and scores responses and write-backs against the queues.
    int            run = 0;
    bit            run_we = 0;
    logic [AW-1:0] run_addr = '0;
    bit            prev_req = 0;

    always @(negedge clk) begin
        exp_t e;
        wb_t  w;
        if (cyc < NLOG) begin
            lg_req[cyc]  = bus.mem_req;
            lg_we[cyc]   = bus.mem_we;
            lg_iv[cyc]   = bus.i_fill_valid;
            lg_dv[cyc]   = bus.d_fill_valid;
            lg_dp[cyc]   = bus.d_pending;
            lg_addr[cyc] = bus.mem_addr;
        end
        if (reset) begin
            run = 0;
            prev_req = 0;
        end else begin
            if (bus.mem_req && !prev_req)
                grant_log.push_back((bus.mem_we || bus.mem_addr >= 32'h100) ? 1 : 0);
            prev_req = bus.mem_req;
            if (run != 0 && !(bus.mem_req && bus.mem_we == run_we && bus.mem_addr == run_addr)) begin
                chk("burst_len", run, L);
                run = 0;
            end
            if (bus.mem_req) begin
                if (run == 0) begin
                    run_we = bus.mem_we;
                    run_addr = bus.mem_addr;
                    if (bus.mem_we) begin
                        if (wb_exp.size() == 0) chk("wb_unexpected", 1, 0);
                        else begin
                            w = wb_exp.pop_front();
                            chk("wb_addr", bus.mem_addr, w.addr);
                            chk("wb_data", bus.mem_wdata, w.data);
                        end
                    end
                end
                run++;
            end
            if (bus.i_fill_valid) begin
                i_resp_cnt++;
                if (i_exp.size() == 0) chk("i_unexpected", 1, 0);
                else begin
                    e = i_exp.pop_front();
                    chk("i_data", bus.i_fill_data, e.data);
                    chk("i_wait_bound", (cyc - e.cyc) <= 4*L+5, 1);
                end
            end
            if (bus.d_fill_valid) begin
                d_resp_cnt++;
                if (d_exp.size() == 0) chk("d_unexpected", 1, 0);
                else begin
                    e = d_exp.pop_front();
                    chk("d_data", bus.d_fill_data, e.data);
                    chk("d_wait_bound", (cyc - e.cyc) <= 3*L+5, 1);
                end
            end
        end
    end

    task automatic issue_i(input logic [AW-1:0] a);
        exp_t e;
        e.data = ref_mem[a[9:4]];
        e.cyc = cyc;
        i_exp.push_back(e);
        bus.i_req = 1; bus.i_addr = a; i_busy = 1;
    endtask

    task automatic issue_d(input logic [AW-1:0] a, input bit wb, input logic [AW-1:0] wa,
                           input logic [LW-1:0] wd);
        exp_t e;
        wb_t  w;
        if (wb) begin
            ref_mem[wa[9:4]] = wd;
            w.addr = wa; w.data = wd;
            wb_exp.push_back(w);
        end
        e.data = ref_mem[a[9:4]];
        e.cyc = cyc;
        d_exp.push_back(e);
        bus.d_req = 1; bus.d_addr = a; bus.d_wb_needed = wb; bus.d_wb_addr = wa; bus.d_wb_data = wd;
        d_busy = 1;
    endtask

    // Advance one cycle; requesters drop on their fill pulse, a cancel lasts one cycle.
    task automatic tick();
        @(posedge clk); #1;
        if (bus.i_cancel) begin
            bus.i_cancel = 0; bus.i_req = 0; i_busy = 0; i_exp.delete(); i_seen = i_resp_cnt;
        end
        if (i_resp_cnt != i_seen) begin i_seen = i_resp_cnt; bus.i_req = 0; i_busy = 0; end
        if (d_resp_cnt != d_seen) begin d_seen = d_resp_cnt; bus.d_req = 0; d_busy = 0; end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((i_busy || d_busy) && n < 400) begin tick(); n++; end
        chk(nm, (i_busy || d_busy), 0);
    endtask

    task automatic check_zero();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_i_valid", bus.i_fill_valid, 0);
        chk("rst_d_valid", bus.d_fill_valid, 0);
        chk("rst_d_pending", bus.d_pending, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_data", bus.i_fill_data, 0);
        chk("rst_d_data", bus.d_fill_data, 0);
    endtask

    function automatic int gl(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, nv;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        bus.i_req = 0; bus.i_addr = '0; bus.i_cancel = 0;
        bus.d_req = 0; bus.d_addr = '0; bus.d_wb_needed = 0; bus.d_wb_addr = '0; bus.d_wb_data = '0;

        // Reset with both requesting: outputs quiet, D wins the first tie.
        issue_i(32'h40);
        issue_d(32'h120, 0, 32'h0, '0);
        @(posedge clk); #1 mem_init = 0;
        @(negedge clk); check_zero();
        @(posedge clk); @(negedge clk); check_zero();
        @(posedge clk); #1 reset = 0;
        drain("rst_drain_timeout");
        chk("first_grant_d", gl(0), 1);

        // Single clean I fill.
        tick(); t = cyc; issue_i(32'h40);
        drain("i_drain_timeout");
        chk("i_addr", lg_addr[t+1], 32'h40);
        for (int k = 0; k <= L+1; k++) begin
            chk("i_mem_req", lg_req[t+k], (k >= 1 && k <= L));
            chk("i_mem_we", lg_we[t+k], 0);
            chk("i_valid_time", lg_iv[t+k], (k == L+1));
        end

        // Dirty D miss: write-back then contiguous fill.
        tick(); t = cyc; issue_d(32'h200, 1, 32'h100, {4{32'hDEADBEEF}});
        drain("dwb_drain_timeout");
        chk("dwb_wr_addr", lg_addr[t+1], 32'h100);
        chk("dwb_rd_addr", lg_addr[t+L+1], 32'h200);
        for (int k = 0; k <= 2*L+2; k++) begin
            chk("dwb_mem_req", lg_req[t+k], (k >= 1 && k <= 2*L));
            chk("dwb_mem_we", lg_we[t+k], (k >= 1 && k <= L));
            chk("dwb_valid_time", lg_dv[t+k], (k == 2*L+1));
            chk("dwb_pending", lg_dp[t+k], (k >= 1 && k <= 2*L+1));
        end

        // Both requesting continuously: grants alternate, I first since D went last.
        grant_log.delete();
        tick(); issue_i(32'h80); issue_d(32'h140, 0, 32'h0, '0);
        for (int n = 0; n < 200 && grant_log.size() < 4; n++) begin
            tick();
            if (!i_busy) issue_i(32'h80);
            if (!d_busy) issue_d(32'h140, 0, 32'h0, '0);
        end
        drain("alt_drain_timeout");
        chk("alt_g0", gl(0), 0);
        chk("alt_g1", gl(1), 1);
        chk("alt_g2", gl(2), 0);
        chk("alt_g3", gl(3), 1);

        // Cancel mid-fill: read completes, no pulse, waiting D granted right after.
        tick(); t = cyc; issue_i(32'h90);
        tick(); tick(); tick();
        bus.i_cancel = 1;
        issue_d(32'h160, 0, 32'h0, '0);
        drain("cancel_drain_timeout");
        chk("cancel_req_first", lg_req[t+1], 1);
        chk("cancel_req_last", lg_req[t+L], 1);
        chk("cancel_no_valid", lg_iv[t+L+1], 0);
        chk("cancel_gap", lg_req[t+L+2], 0);
        chk("cancel_d_start", lg_req[t+L+3], 1);
        chk("cancel_d_addr", lg_addr[t+L+3], 32'h160);

        // Reset in the middle of an I fill: access abandoned, no response.
        tick(); t = cyc; issue_i(32'hA0);
        tick(); tick(); tick();
        reset = 1;
        tick();
        reset = 0; bus.i_req = 0; i_busy = 0; i_exp.delete();
        repeat (3*L) tick();
        chk("rmid_req_before", lg_req[t+3], 1);
        chk("rmid_req_after", lg_req[t+4], 0);
        nv = 0;
        for (int k = 4; k <= 3*L+3; k++) nv += lg_iv[t+k];
        chk("rmid_no_valid", nv, 0);

        // Random traffic with cancels and dirty victims.
        for (int n = 0; n < 2500; n++) begin
            tick();
            if (!i_busy && $urandom_range(0, 2) == 0)
                issue_i({$urandom_range(0, 15), 4'h0});
            else if (i_busy && $urandom_range(0, 9) == 0)
                bus.i_cancel = 1;
            if (!d_busy && $urandom_range(0, 2) == 0)
                issue_d(32'h100 + 32'($urandom_range(0, 15)) * 16, 1'($urandom_range(0, 1)),
                        32'h100 + 32'($urandom_range(0, 15)) * 16,
                        {$urandom, $urandom, $urandom, $urandom});
        end
        drain("rand_drain_timeout");
        repeat (4) tick();
        chk("wb_queue_empty", wb_exp.size(), 0);
        chk("d_queue_empty", d_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single main-memory port between the I-cache line fill and the D-cache miss path (optional dirty-line write-back, then line fill). It sits below both caches. Its fill responses are what clear the fetch stage's `instruction_not_ready` and the memory stage's `d_cache_miss` / `enable_write_from_cache_to_memory` stalls in the pipeline stall logic. Memory has a fixed access latency; the arbiter holds the port stable for that latency and returns one registered response pulse per transaction.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, cache line width in bits
- `MEM_LATENCY`, 5, memory access cycles per transaction (≥1)

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_req`  in  1  I-cache fill request; held high until `i_fill_valid` or cancel
- `i_addr`  in  ADDR_W  I-cache fill line address
- `i_cancel`  in  1  fetch redirect; the current I request is no longer wanted
- `i_fill_valid`  out  1  one-cycle pulse; `i_fill_data` is valid
- `i_fill_data`  out  LINE_W  I line data
- `d_req`  in  1  D-cache miss request; held high until `d_fill_valid`
- `d_addr`  in  ADDR_W  D fill line address
- `d_wb_needed`  in  1  the victim line is dirty; write it back before the fill
- `d_wb_addr`  in  ADDR_W  victim line address
- `d_wb_data`  in  LINE_W  victim line data
- `d_fill_valid`  out  1  one-cycle pulse; `d_fill_data` is valid
- `d_fill_data`  out  LINE_W  D line data
- `d_pending`  out  1  a D transaction is accepted and not yet responded
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  LINE_W  write data
- `mem_rdata`  in  LINE_W  read data; valid in the last cycle of an access

## Operation
- **States:**
  - `IDLE`: nothing in flight.
  - `I_FILL`: I-cache line read in progress.
  - `D_WB`: D-cache victim write-back in progress.
  - `D_FILL`: D-cache line read in progress.
  - `RESP`: one-cycle response state.
- **IDLE arbitration, when only one request is pending:** that request wins.
  - An I request qualifies only when `i_req && !i_cancel`.
  - A D request is pending when `d_req` is high.
- **IDLE arbitration, when both are pending:** the requester *not* granted last wins. `last_grant` resets to I, so D wins the first tie.
- **Grant effects:**
  - Address, write-back data and `d_wb_needed` are latched at grant.
  - `last_grant` updates at grant.
- **Transitions:**
  - I grant → `I_FILL` → `RESP`.
  - D grant with `d_wb_needed` → `D_WB` → `D_FILL` → `RESP`.
  - D grant without `d_wb_needed` → `D_FILL` → `RESP`.
  - `RESP` → `IDLE` unconditionally.
- **Memory port per access state:**
  - `mem_req` is 1 and the address/data are stable for exactly `MEM_LATENCY` cycles.
  - A down-counter of width $clog2(MEM_LATENCY) loads `MEM_LATENCY-1` on state entry. The state exits when the counter is 0.
  - `mem_we` = 1 only in `D_WB`.
- **Read capture:** `mem_rdata` is captured when the counter is 0 in `I_FILL` / `D_FILL`.
- **Response:**
  - In `RESP`, `i_fill_valid` or `d_fill_valid` is 1 for that single cycle.
  - Fill data is held until the next capture.
- **Cancel:**
  - `i_cancel` in any cycle of `I_FILL` sets a `cancelled` flag.
  - The memory read still completes; memory is never aborted.
  - In `RESP`, `i_fill_valid` is suppressed.
  - `cancelled` clears on entry to `IDLE`.
- **`d_pending`:** 1 from the cycle after a D grant through the `RESP` cycle, inclusive.
- **Outputs in IDLE/RESP:** `mem_req` = 0, `mem_we` = 0.

## Timing
- **Reset:** when `reset` is sampled high, the next state is `IDLE`.
  - All outputs are 0: `mem_req`, `mem_we`, both valid pulses, `d_pending`, `mem_addr`, `mem_wdata`, and both fill data buses.
  - `last_grant` = I; `cancelled` = 0.
- **Reset mid-transaction:** the transaction is abandoned with no response pulse. Requesters reissue.
- **Latency, request sampled in IDLE at cycle t:**
  - Clean access: `mem_req` high t+1 … t+L; response pulse at t+L+1.
  - Dirty D miss: write at t+1 … t+L; read at t+L+1 … t+2L; `d_fill_valid` at t+2L+1.
  - Earliest next grant is sampled at t+L+2 (clean) or t+2L+2 (dirty). The `RESP` cycle guarantees a held request is not regranted in its own response cycle.
- **Back-to-back:** writes and reads are contiguous; there is no idle gap between `D_WB` and `D_FILL`.
- **`MEM_LATENCY` = 1:** each access state lasts one cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (`IDLE`, `I_FILL`, `D_WB`, `D_FILL`, `RESP`);
  - grant-id constants (`GNT_I`, `GNT_D`).
- One sub-module, `mem_latency_counter`:
  - inputs: load, `MEM_LATENCY` parameter;
  - output: a `done` flag.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Reset state:** hold `reset` 2 cycles with `i_req` = `d_req` = 1 → all outputs 0 during reset; D is granted first after release.
- **Single I fill, L=5:** `i_req` at t=0, addr `0x40`, `mem_rdata` = `0xA5…` → `mem_req` t=1..5, `mem_we` = 0, `i_fill_valid` at t=6 with the data.
- **Dirty D miss:** `d_wb_needed` = 1, wb addr `0x100`, fill addr `0x200`.
  - `mem_we` = 1 at `0x100` for t=1..5.
  - Read of `0x200` for t=6..10.
  - `d_fill_valid` at t=11; `d_pending` is 1 for t=1..11.
- **Both requesting continuously:** grants alternate D, I, D, I; no requester waits more than one transaction.
- **Cancel:** `i_cancel` at t=3 of an I fill → memory read still spans t=1..5, no `i_fill_valid` at t=6, and a pending D request is granted from t=7.
- **Reset mid-access:** reset at t=3 of an I fill → `mem_req` = 0 from t=4 and no response pulse ever appears.
